// File: rtl/trace_pkg.sv
// Shared types and the signature step function for the commit trace monitor.
// Widths here are the defaults used by the standard core configuration.
package trace_pkg;

  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_CYC_W  = 32;
  localparam int SIG_MAX_W    = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]              ch;
    logic [4:0]              rd;
    logic [TRACE_DATA_W-1:0] data;
    logic [TRACE_CYC_W-1:0]  cycle;
  } trace_entry_t;

  // One signature step over a w-bit signature (w <= 64):
  // sig = rotl(sig,1) ^ data ^ (rd << 8) ^ ch, confined to the low w bits.
  function automatic logic [SIG_MAX_W-1:0] sig_step(
    input logic [SIG_MAX_W-1:0] sig,
    input int unsigned          w,
    input logic [1:0]           ch,
    input logic [4:0]           rd,
    input logic [SIG_MAX_W-1:0] data
  );
    logic [SIG_MAX_W-1:0] mask;
    logic [SIG_MAX_W-1:0] s;
    logic [SIG_MAX_W-1:0] rot;
    mask = (w >= SIG_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    s    = sig & mask;
    rot  = ((s << 1) | (s >> (w - 1))) & mask;
    return (rot ^ data ^ (64'(rd) << 8) ^ 64'(ch)) & mask;
  endfunction

endpackage

// File: rtl/trace_fifo_mw.sv
// Multi-write, single-read FIFO. Up to NUM_W pushes per cycle are packed in
// ascending port order into the free space; the rest are refused.
module trace_fifo_mw
  import trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  NUM_W = 2,
  parameter type entry_t = trace_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int ACC_W = $clog2(NUM_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [NUM_W-1:0] push_i,
  input  entry_t           push_data_i [NUM_W],
  input  logic             pop_i,
  output logic             valid_o,
  output entry_t           head_o,
  output logic [ACC_W-1:0] accepted_o
);

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pop_ok;
  logic [NUM_W-1:0] wr_en;
  logic [AW-1:0]    wr_idx [NUM_W];
  int               slot;
  int               free;

  // NOTE: always_comb uses blocking assignments and gives every output a
  // default before any branch, so no latch can be inferred.
  always_comb begin
    pop_ok = pop_i && (count_q != '0) && !clear_i;
    free   = DEPTH - int'(count_q) + (pop_ok ? 1 : 0);
    slot   = 0;
    for (int c = 0; c < NUM_W; c++) begin
      wr_en[c]  = 1'b0;
      wr_idx[c] = wr_ptr_q + AW'(slot);
      if (push_i[c] && !clear_i && (slot < free)) begin
        wr_en[c] = 1'b1;
        slot     = slot + 1;
      end
    end
    accepted_o = ACC_W'(slot);

    wr_ptr_d = wr_ptr_q + AW'(slot);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CNT_W'(slot) - CNT_W'(pop_ok);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is tracked
  // by count_q and the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_W; c++) begin
      if (wr_en[c]) mem[wr_idx[c]] <= push_data_i[c];
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/commit_trace_monitor.sv
// Write-back commit monitor: traces register writes, keeps a running
// signature and counters, and flags program end (PC self-loop) or timeout.
module commit_trace_monitor
  import trace_pkg::*;
#(
  parameter int                WIDTH       = 32,
  parameter int                NUM_CH      = 2,
  parameter int                DEPTH       = 16,
  parameter int                CYC_W       = 32,
  parameter int                HALT_CYCLES = 64,
  parameter int                MAX_CYCLES  = 3000,
  parameter logic [NUM_CH-1:0] ZERO_MASK   = 'b01
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_clear,
  input  logic [WIDTH-1:0]    i_pc,
  input  logic [NUM_CH-1:0]   i_wb_valid,
  input  logic [5*NUM_CH-1:0] i_wb_rd,
  input  logic [WIDTH*NUM_CH-1:0] i_wb_data,
  input  logic                i_trace_pop,
  output logic                o_trace_valid,
  output logic [1:0]          o_trace_ch,
  output logic [4:0]          o_trace_rd,
  output logic [WIDTH-1:0]    o_trace_data,
  output logic [CYC_W-1:0]    o_trace_cycle,
  output logic                o_overflow,
  output logic [15:0]         o_drop_cnt,
  output logic [WIDTH-1:0]    o_signature,
  output logic [CYC_W-1:0]    o_commit_cnt,
  output logic [CYC_W-1:0]    o_cycle,
  output logic [1:0]          o_state,
  output logic                o_done
);

  localparam int STAB_W = $clog2(HALT_CYCLES + 1);
  localparam int ACC_W  = $clog2(NUM_CH + 1);

  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_ch
    $error("NUM_CH must be in 1..4");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 4");
  end

  typedef struct packed {
    logic [1:0]       ch;
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
    logic [CYC_W-1:0] cycle;
  } entry_t;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    prev_pc_q, prev_pc_d;
  logic [STAB_W-1:0]   stable_q, stable_d;
  logic [CYC_W-1:0]    cycle_q, cycle_d;
  logic [CYC_W-1:0]    commit_q, commit_d;
  logic [WIDTH-1:0]    sig_q, sig_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_q, drop_d;

  logic [NUM_CH-1:0]   ev_valid;
  logic [NUM_CH-1:0]   push;
  entry_t              push_data [NUM_CH];
  entry_t              head;
  logic                head_valid;
  logic [ACC_W-1:0]    accepted;

  logic                pc_match;
  logic [WIDTH-1:0]    sig_v;
  int                  n_valid;
  int                  n_drop;
  logic [CYC_W:0]      commit_sum;
  logic [16:0]         drop_sum;

  // Qualify each channel and build its trace entry, stamped with the
  // cycle count before this cycle's increment.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ev_valid[c]  = i_wb_valid[c] && (state_q == RUN) &&
                     !(ZERO_MASK[c] && (i_wb_rd[5*c +: 5] == 5'd0));
      push_data[c] = '{ch:    2'(c),
                       rd:    i_wb_rd[5*c +: 5],
                       data:  i_wb_data[WIDTH*c +: WIDTH],
                       cycle: cycle_q};
    end
    push = ev_valid & {NUM_CH{~i_clear}};
  end

  trace_fifo_mw #(
    .DEPTH   (DEPTH),
    .NUM_W   (NUM_CH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .clear_i     (i_clear),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (i_trace_pop),
    .valid_o     (head_valid),
    .head_o      (head),
    .accepted_o  (accepted)
  );

  always_comb begin
    state_d    = state_q;
    prev_pc_d  = i_pc;
    stable_d   = stable_q;
    cycle_d    = cycle_q;
    overflow_d = overflow_q;
    pc_match   = (i_pc == prev_pc_q);

    if (!pc_match) begin
      stable_d = '0;
    end else if (state_q == RUN) begin
      stable_d = stable_q + STAB_W'(1);
    end

    unique case (state_q)
      IDLE: if (i_start) state_d = RUN;
      RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + CYC_W'(1);
        // A PC self-loop takes precedence over a simultaneous timeout.
        if (pc_match && (stable_q == STAB_W'(HALT_CYCLES - 1))) begin
          state_d = HALTED;
        end else if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
          state_d = TIMEOUT;
        end
      end
      default: ;
    endcase

    sig_v   = sig_q;
    n_valid = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ev_valid[c]) begin
        sig_v   = WIDTH'(sig_step(64'(sig_v), WIDTH, 2'(c), i_wb_rd[5*c +: 5],
                                  64'(i_wb_data[WIDTH*c +: WIDTH])));
        n_valid = n_valid + 1;
      end
    end
    sig_d = sig_v;

    commit_sum = {1'b0, commit_q} + (CYC_W + 1)'(n_valid);
    commit_d   = commit_sum[CYC_W] ? '1 : commit_sum[CYC_W-1:0];

    n_drop   = n_valid - int'(accepted);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
    if (n_drop != 0) overflow_d = 1'b1;

    if (i_clear) begin
      state_d    = IDLE;
      prev_pc_d  = '0;
      stable_d   = '0;
      cycle_d    = '0;
      commit_d   = '0;
      sig_d      = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      prev_pc_q  <= '0;
      stable_q   <= '0;
      cycle_q    <= '0;
      commit_q   <= '0;
      sig_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_pc_q  <= prev_pc_d;
      stable_q   <= stable_d;
      cycle_q    <= cycle_d;
      commit_q   <= commit_d;
      sig_q      <= sig_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign o_trace_valid = head_valid;
  assign o_trace_ch    = head.ch;
  assign o_trace_rd    = head.rd;
  assign o_trace_data  = head.data;
  assign o_trace_cycle = head.cycle;
  assign o_overflow    = overflow_q;
  assign o_drop_cnt    = drop_q;
  assign o_signature   = sig_q;
  assign o_commit_cnt  = commit_q;
  assign o_cycle       = cycle_q;
  assign o_state       = state_q;
  assign o_done        = (state_q == HALTED) || (state_q == TIMEOUT);

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor with hand-computed expectations.
module tb_commit_trace_monitor;

  localparam int WIDTH  = 32;
  localparam int NUM_CH = 2;
  localparam int CYC_W  = 32;

  logic                    i_clk;
  logic                    i_rst_n;
  logic                    i_start;
  logic                    i_clear;
  logic [WIDTH-1:0]        i_pc;
  logic [NUM_CH-1:0]       i_wb_valid;
  logic [5*NUM_CH-1:0]     i_wb_rd;
  logic [WIDTH*NUM_CH-1:0] i_wb_data;
  logic                    i_trace_pop;
  logic                    o_trace_valid;
  logic [1:0]              o_trace_ch;
  logic [4:0]              o_trace_rd;
  logic [WIDTH-1:0]        o_trace_data;
  logic [CYC_W-1:0]        o_trace_cycle;
  logic                    o_overflow;
  logic [15:0]             o_drop_cnt;
  logic [WIDTH-1:0]        o_signature;
  logic [CYC_W-1:0]        o_commit_cnt;
  logic [CYC_W-1:0]        o_cycle;
  logic [1:0]              o_state;
  logic                    o_done;

  commit_trace_monitor #(
    .WIDTH       (WIDTH),
    .NUM_CH      (NUM_CH),
    .DEPTH       (16),
    .CYC_W       (CYC_W),
    .HALT_CYCLES (64),
    .MAX_CYCLES  (3000),
    .ZERO_MASK   (2'b01)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_clear       (i_clear),
    .i_pc          (i_pc),
    .i_wb_valid    (i_wb_valid),
    .i_wb_rd       (i_wb_rd),
    .i_wb_data     (i_wb_data),
    .i_trace_pop   (i_trace_pop),
    .o_trace_valid (o_trace_valid),
    .o_trace_ch    (o_trace_ch),
    .o_trace_rd    (o_trace_rd),
    .o_trace_data  (o_trace_data),
    .o_trace_cycle (o_trace_cycle),
    .o_overflow    (o_overflow),
    .o_drop_cnt    (o_drop_cnt),
    .o_signature   (o_signature),
    .o_commit_cnt  (o_commit_cnt),
    .o_cycle       (o_cycle),
    .o_state       (o_state),
    .o_done        (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int  checks = 0;
  int  errors = 0;
  bit  pc_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (!pc_hold) i_pc = i_pc + 32'd4;
  endtask

  task automatic wb(input logic [1:0] valid, input logic [4:0] rd1, input logic [4:0] rd0,
                    input logic [31:0] d1, input logic [31:0] d0);
    i_wb_valid = valid;
    i_wb_rd    = {rd1, rd0};
    i_wb_data  = {d1, d0};
  endtask

  task automatic pop_n(input int n);
    i_trace_pop = 1'b1;
    repeat (n) tick();
    i_trace_pop = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [1:0] ch,
                            input logic [4:0] rd, input logic [31:0] d);
    check({tag, "_valid"}, o_trace_valid, v);
    check({tag, "_ch"},    o_trace_ch, ch);
    check({tag, "_rd"},    o_trace_rd, rd);
    check({tag, "_data"},  o_trace_data, d);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b1; i_clear = 1'b0; i_pc = 32'h100;
    i_trace_pop = 1'b0;
    wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);

    // Reset with start held: nothing may leave IDLE.
    repeat (3) tick();
    check("rst_state", o_state, 2'd0);
    check("rst_cycle", o_cycle, 0);
    check("rst_sig", o_signature, 0);
    check_head("rst_head", 1'b0, 2'd0, 5'd0, 32'd0);
    check("rst_cycle_stamp", o_trace_cycle, 0);
    check("rst_misc", {o_overflow, o_drop_cnt, o_commit_cnt, o_done}, 0);
    i_start = 1'b0;
    i_rst_n = 1'b1;
    tick();
    check("idle_state", o_state, 2'd0);

    // Start; o_cycle counts RUN cycles.
    i_start = 1'b1; tick(); i_start = 1'b0;
    check("run_state", o_state, 2'd1);
    check("run_cycle0", o_cycle, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("run_cycle_inc", o_cycle, 32'(k));
    end

    // ch0 x5 at cycle 3, then ch0 x0 (masked).
    wb(2'b01, 5'd0, 5'd5, 32'd0, 32'h0000_A700); tick();
    check_head("x5", 1'b1, 2'd0, 5'd5, 32'h0000_A700);
    check("x5_stamp", o_trace_cycle, 3);
    check("x5_sig", o_signature, 32'h0000_A200);
    check("x5_cnt", o_commit_cnt, 1);
    wb(2'b01, 5'd0, 5'd0, 32'd0, 32'h1234); tick();
    wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("x0_cnt", o_commit_cnt, 1);
    check("x0_sig", o_signature, 32'h0000_A200);
    pop_n(1);
    check_head("x5_popped", 1'b0, 2'd0, 5'd0, 32'd0);

    // Clear restores reset values.
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    check("clr_state", o_state, 2'd0);
    check("clr_all", {o_signature, o_commit_cnt, o_cycle}, 0);

    // Two channels in one cycle: ch0 first.
    i_start = 1'b1; tick(); i_start = 1'b0;
    wb(2'b11, 5'd2, 5'd1, 32'h22, 32'h11); tick();
    wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check_head("dual0", 1'b1, 2'd0, 5'd1, 32'h11);
    check("dual_sig", o_signature, 32'h0000_0001);
    check("dual_cnt", o_commit_cnt, 2);
    pop_n(1);
    check_head("dual1", 1'b1, 2'd1, 5'd2, 32'h22);
    pop_n(2);  // second pop lands on an empty FIFO
    check_head("dual_empty", 1'b0, 2'd0, 5'd0, 32'd0);

    // Fill to 15, then two events with no pop: ch0 accepted, ch1 dropped.
    for (int i = 0; i < 15; i++) begin
      wb(2'b01, 5'd0, 5'd3, 32'd0, 32'h100 + 32'(i)); tick();
    end
    wb(2'b11, 5'd4, 5'd4, 32'hC1, 32'hC0); tick();
    wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("full_ovf", o_overflow, 1'b1);
    check("full_drop", o_drop_cnt, 1);
    check("full_cnt", o_commit_cnt, 19);
    check_head("full_head", 1'b1, 2'd0, 5'd3, 32'h100);

    // Back to 15 entries; two events with pop are both accepted.
    pop_n(1);
    i_trace_pop = 1'b1;
    wb(2'b11, 5'd6, 5'd6, 32'hD1, 32'hD0); tick();
    i_trace_pop = 1'b0;
    wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("pop_drop", o_drop_cnt, 1);
    pop_n(13);
    check_head("ord_c0", 1'b1, 2'd0, 5'd4, 32'hC0);
    pop_n(1);
    check_head("ord_d0", 1'b1, 2'd0, 5'd6, 32'hD0);
    pop_n(1);
    check_head("ord_d1", 1'b1, 2'd1, 5'd6, 32'hD1);
    pop_n(1);
    check("ord_empty", o_trace_valid, 1'b0);

    // PC held at 0x40: HALTED on the 64th RUN cycle.
    pc_hold = 1'b1; i_pc = 32'h40;
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    repeat (63) tick();
    check("halt_pre_state", o_state, 2'd1);
    check("halt_pre_cycle", o_cycle, 63);
    tick();
    check("halt_state", o_state, 2'd2);
    check("halt_done", o_done, 1'b1);
    check("halt_cycle", o_cycle, 64);
    wb(2'b01, 5'd0, 5'd7, 32'd0, 32'h77); i_start = 1'b1; tick();
    wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0); i_start = 1'b0; tick();
    check("halt_ignore_cnt", o_commit_cnt, 0);
    check("halt_ignore_fifo", o_trace_valid, 1'b0);
    check("halt_sticky", o_state, 2'd2);
    check("halt_frozen", o_cycle, 64);

    // Toggling PC: TIMEOUT after the RUN cycle with o_cycle == 2999.
    pc_hold = 1'b0;
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    wb(2'b10, 5'd9, 5'd0, 32'h5, 32'd0); tick();
    wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    repeat (2998) tick();
    check("to_pre_state", o_state, 2'd1);
    check("to_pre_cycle", o_cycle, 2999);
    tick();
    check("to_state", o_state, 2'd3);
    check("to_done", o_done, 1'b1);
    check("to_cycle", o_cycle, 3000);
    check("to_sig", o_signature, 32'h0000_0904);
    check("to_fifo", o_trace_valid, 1'b1);
    tick();
    check("to_sticky", o_state, 2'd3);

    // Asynchronous reset mid-TIMEOUT takes effect before any clock edge.
    i_rst_n = 1'b0;
    #1;
    check("arst_state", o_state, 2'd0);
    check("arst_done", o_done, 1'b0);
    check("arst_zero", {o_signature, o_cycle, o_commit_cnt}, 0);
    check("arst_fifo", o_trace_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
- Synthesizable commit monitor for the pipelined RISC-V core. Attaches to the write-back ports: integer channel and FP channel.
- Records every architectural register write into a trace FIFO, with a cycle stamp on each entry.
- Keeps a running commit signature and commit/cycle counters.
- Detects end of program (PC self-loop) or timeout, so benches and FPGA builds stop on a hardware condition rather than a fixed cycle count.

Parameters:
- WIDTH, 32, data/PC width.
- NUM_CH, 2, write-back channels. ch0 = integer x-file, ch1 = FP f-file. Legal range 1..4.
- DEPTH, 16, trace FIFO entries. Must be a power of 2, at least 4.
- CYC_W, 32, width of the cycle and commit counters.
- HALT_CYCLES, 64, consecutive cycles of unchanged PC that declare a halt.
- MAX_CYCLES, 3000, RUN cycles before timeout.
- ZERO_MASK, 'b01, per-channel bit. When set, writes to rd==0 on that channel are ignored.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  pulse; IDLE->RUN
- i_clear  in  1  synchronous clear of all state to reset values
- i_pc  in  WIDTH  fetch PC
- i_wb_valid  in  NUM_CH  per-channel register-write enable at WB
- i_wb_rd  in  5*NUM_CH  per-channel destination index; channel c at [5c+4:5c]
- i_wb_data  in  WIDTH*NUM_CH  per-channel write data
- i_trace_pop  in  1  consume head entry
- o_trace_valid  out  1  FIFO non-empty
- o_trace_ch  out  2  head channel
- o_trace_rd  out  5  head rd
- o_trace_data  out  WIDTH  head data
- o_trace_cycle  out  CYC_W  head cycle stamp
- o_overflow  out  1  sticky: at least one entry dropped
- o_drop_cnt  out  16  dropped entries, saturating
- o_signature  out  WIDTH  running commit signature
- o_commit_cnt  out  CYC_W  accepted commits
- o_cycle  out  CYC_W  RUN cycles elapsed
- o_state  out  2  IDLE=0, RUN=1, HALTED=2, TIMEOUT=3
- o_done  out  1  state is HALTED or TIMEOUT

Behaviour:
- Reset (async, i_rst_n low): all outputs 0, state IDLE, FIFO empty, stable counter 0. i_clear has the same effect synchronously and takes priority over every other input that cycle.
- FSM:
  - IDLE->RUN on i_start.
  - RUN->HALTED when the stable counter reaches HALT_CYCLES-1 with i_pc unchanged.
  - RUN->TIMEOUT when o_cycle == MAX_CYCLES-1.
  - If both fire in the same cycle, HALTED wins.
  - HALTED and TIMEOUT are sticky until reset or i_clear. i_start is ignored outside IDLE.
- Stable counter:
  - Compares i_pc against a registered previous PC.
  - Set to 0 on mismatch; incremented on match while in RUN.
- o_cycle: increments every RUN cycle, saturates at all-ones, frozen in every other state.
- Commit qualification: event c is valid when i_wb_valid[c] is set, state is RUN, and NOT (ZERO_MASK[c] and rd==0). Inputs are ignored outside RUN.
- Signature:
  - For each valid event, in ascending channel order within the cycle: sig = rotl(sig,1) ^ data ^ (rd<<8) ^ c.
  - Updated for every valid event, whether or not it entered the FIFO.
  - o_commit_cnt increments by the number of valid events that cycle, saturating.
- FIFO:
  - Accepts up to NUM_CH pushes per cycle, in ascending channel order.
  - Free space = DEPTH - count + (pop accepted ? 1 : 0).
  - Events beyond the free space are dropped: o_overflow is set and o_drop_cnt increases by the number dropped.
  - The cycle stamp is o_cycle before that cycle's increment.
  - Pop is ignored when empty.
  - Push and pop in the same cycle are allowed when full.
  - Head outputs are registered-read with 0-cycle latency from o_trace_valid; head fields are 0 when empty.
  - Pointers wrap modulo DEPTH.
- Latency: a WB event is visible at the FIFO head in the next cycle if the FIFO was empty. o_signature and o_commit_cnt also update in the next cycle.

Decomposition:
- Package trace_pkg holds:
  - typedef state_e (IDLE/RUN/HALTED/TIMEOUT).
  - struct trace_entry_t {ch[1:0], rd[4:0], data, cycle}.
  - Function sig_step(sig, ch, rd, data).
- One sub-module: trace_fifo_mw, a multi-write single-read FIFO of trace_entry_t. Parameters DEPTH and NUM_W; it reports the per-cycle accepted count.
- FSM, counters and signature live in the top module.

Test Plan:
- Reset with i_start held, then release: o_state=0, all outputs 0. Pulse i_start -> o_state=1 next cycle, o_cycle increments by 1 per clock.
- ch0 writes x5=0x0000A700 at cycle 3, and ch0 writes rd=0 -> one entry {ch0, rd5, 0xA700, cycle 3}. Signature = 0xA700^0x500; o_commit_cnt=1.
- ch0 x1=0x11 and ch1 f2=0x22 in the same cycle, FIFO empty -> two entries, order ch0 then ch1. Signature = rotl(0x111,1)^0x22^0x201 = 0x000001 (matches sig_step chain); commit_cnt=2.
- Fill to 15 entries, then issue 2 simultaneous events with no pop -> 1 accepted (ch0), o_drop_cnt=1, o_overflow=1. Same case with pop asserted -> both accepted, no drop.
- Hold i_pc=0x0000_0040 constant for 64 cycles in RUN -> o_state=2 and o_done=1 on the 64th cycle. Further events are ignored.
- Toggle i_pc every cycle with MAX_CYCLES=3000 -> o_state=3 when o_cycle=2999. Then assert reset mid-TIMEOUT -> all outputs 0 and IDLE immediately (asynchronous).
